// File: rtl/karatsuba_dec_seq_ctrl.sv
// ---------------------------------------------------------------------------
// karatsuba_dec_seq_ctrl
//
// Sequential Karatsuba controller for an 8-digit x 8-digit decimal multiply.
// Operands arrive as four base-BASE halves. One external combinational
// signed multiplier is time-shared across three partial products:
//    p1 = a_hi*b_hi, p2 = a_lo*b_lo, p3 = (a_hi+a_lo)*(b_hi+b_lo)
// which are then recombined as
//    result = p1*BASE^2 + (p3-p1-p2)*BASE + p2   (modulo 2^64).
//
// Ports:
//    clk, rst_n          clock, asynchronous active-low reset
//    in_valid/in_ready   operand handshake (in_ready only high in IDLE)
//    a_hi,a_lo,b_hi,b_lo operand halves, unsigned, expected < BASE
//    out_valid/out_ready result handshake
//    result              64-bit product, held stable while out_valid
//    out_err             some captured half was >= BASE (qualified by out_valid)
//    mul_x, mul_y        operands driven to the shared multiplier
//    mul_p               product returned combinationally by the multiplier
//    busy                high whenever not IDLE
//    op_count            count of completed output handshakes (wraps)
// ---------------------------------------------------------------------------
module karatsuba_dec_seq_ctrl #(
   parameter int WIDTH = 16,
   parameter int BASE  = 10000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a_hi,
   input  logic [WIDTH-1:0]     a_lo,
   input  logic [WIDTH-1:0]     b_hi,
   input  logic [WIDTH-1:0]     b_lo,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [63:0]          result,
   output logic                 out_err,
   output logic [WIDTH-1:0]     mul_x,
   output logic [WIDTH-1:0]     mul_y,
   input  logic [2*WIDTH-1:0]   mul_p,
   output logic                 busy,
   output logic [15:0]          op_count
);

   typedef enum logic [2:0] {
      IDLE,
      MUL_HI,
      MUL_LO,
      MUL_MID,
      COMBINE,
      DONE
   } state_t;

   localparam logic [WIDTH-1:0] BASE_W  = WIDTH'(BASE);
   localparam logic [63:0]      BASE_64 = 64'(BASE);

   state_t               r_state;
   state_t               w_nextState;

   logic [WIDTH-1:0]     r_aHi;
   logic [WIDTH-1:0]     r_aLo;
   logic [WIDTH-1:0]     r_bHi;
   logic [WIDTH-1:0]     r_bLo;
   logic                 r_err;
   logic [2*WIDTH-1:0]   r_p1;
   logic [2*WIDTH-1:0]   r_p2;
   logic [2*WIDTH-1:0]   r_p3;
   logic [63:0]          r_result;
   logic                 r_outErr;
   logic [15:0]          r_opCount;

   logic [WIDTH-1:0]     w_sumA;
   logic [WIDTH-1:0]     w_sumB;
   logic                 w_inErr;
   logic [63:0]          w_p1Ext;
   logic [63:0]          w_p2Ext;
   logic [63:0]          w_p3Ext;
   logic [63:0]          w_combined;

   // Middle-term operand sums are deliberately truncated to the multiplier
   // width; with decimal halves they stay below 2*BASE, which fits as a
   // positive value in the signed multiplier at the default sizes.
   assign w_sumA = WIDTH'(r_aHi + r_aLo);
   assign w_sumB = WIDTH'(r_bHi + r_bLo);

   // Any out-of-range half flags the whole operation; the arithmetic still
   // runs on the raw values.
   assign w_inErr = (a_hi >= BASE_W) | (a_lo >= BASE_W) |
                    (b_hi >= BASE_W) | (b_lo >= BASE_W);

   // Partial products are treated as unsigned and recombined at 64 bits, so
   // the subtraction in the middle term simply wraps if it ever goes negative.
   assign w_p1Ext    = {{(64-2*WIDTH){1'b0}}, r_p1};
   assign w_p2Ext    = {{(64-2*WIDTH){1'b0}}, r_p2};
   assign w_p3Ext    = {{(64-2*WIDTH){1'b0}}, r_p3};
   assign w_combined = (w_p1Ext * BASE_64 * BASE_64)
                     + ((w_p3Ext - w_p1Ext - w_p2Ext) * BASE_64)
                     + w_p2Ext;

   assign result   = r_result;
   assign out_err  = r_outErr;
   assign op_count = r_opCount;

   // State register; reset drops back to IDLE from anywhere, abandoning any
   // operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and state-decoded outputs. The multiplier operands are
   // driven purely from state so the product on mul_p belongs to the
   // partial product being captured at the end of that same cycle.
   always_comb begin
      w_nextState = r_state;
      in_ready    = 1'b0;
      busy        = 1'b1;
      out_valid   = 1'b0;
      mul_x       = '0;
      mul_y       = '0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               w_nextState = MUL_HI;
            end
         end
         MUL_HI: begin
            mul_x       = r_aHi;
            mul_y       = r_bHi;
            w_nextState = MUL_LO;
         end
         MUL_LO: begin
            mul_x       = r_aLo;
            mul_y       = r_bLo;
            w_nextState = MUL_MID;
         end
         MUL_MID: begin
            mul_x       = w_sumA;
            mul_y       = w_sumB;
            w_nextState = COMBINE;
         end
         COMBINE: begin
            w_nextState = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Datapath: operand capture on acceptance, one partial product per
   // multiply state, recombination in COMBINE, and the handshake counter.
   // result/out_err are only written in COMBINE so they hold through DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_aHi     <= '0;
         r_aLo     <= '0;
         r_bHi     <= '0;
         r_bLo     <= '0;
         r_err     <= 1'b0;
         r_p1      <= '0;
         r_p2      <= '0;
         r_p3      <= '0;
         r_result  <= '0;
         r_outErr  <= 1'b0;
         r_opCount <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_aHi <= a_hi;
                  r_aLo <= a_lo;
                  r_bHi <= b_hi;
                  r_bLo <= b_lo;
                  r_err <= w_inErr;
               end
            end
            MUL_HI: begin
               r_p1 <= mul_p;
            end
            MUL_LO: begin
               r_p2 <= mul_p;
            end
            MUL_MID: begin
               r_p3 <= mul_p;
            end
            COMBINE: begin
               r_result <= w_combined;
               r_outErr <= r_err;
            end
            DONE: begin
               if (out_ready) begin
                  r_opCount <= r_opCount + 16'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_karatsuba_dec_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_karatsuba_dec_seq_ctrl
//
// Self-checking bench for karatsuba_dec_seq_ctrl. A behavioural signed
// multiplier answers mul_x/mul_y combinationally. Expected results are
// computed from the operand halves and queued on acceptance, then popped
// and compared when the DUT presents out_valid.
// ---------------------------------------------------------------------------
module tb_karatsuba_dec_seq_ctrl;

   typedef struct {
      logic [63:0] res;
      logic        err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   a_hi;
   logic [15:0]   a_lo;
   logic [15:0]   b_hi;
   logic [15:0]   b_lo;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   result;
   logic          out_err;
   logic [15:0]   mul_x;
   logic [15:0]   mul_y;
   logic [31:0]   mul_p;
   logic          busy;
   logic [15:0]   op_count;

   exp_t          sbQueue[$];
   int            testsRun    = 0;
   int            testsFailed = 0;

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Shared signed multiplier: sign-extend both operands, keep the low 32 bits.
   assign mul_p = {{16{mul_x[15]}}, mul_x} * {{16{mul_y[15]}}, mul_y};

   karatsuba_dec_seq_ctrl #(.WIDTH(16), .BASE(10000)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_hi      (a_hi),
      .a_lo      (a_lo),
      .b_hi      (b_hi),
      .b_lo      (b_lo),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .out_err   (out_err),
      .mul_x     (mul_x),
      .mul_y     (mul_y),
      .mul_p     (mul_p),
      .busy      (busy),
      .op_count  (op_count)
   );

   // Reference: the Karatsuba identity evaluated directly at 64 bits.
   function automatic exp_t modelOp(input logic [15:0] ah, input logic [15:0] al,
                                    input logic [15:0] bh, input logic [15:0] bl);
      exp_t        e;
      logic [15:0] sa;
      logic [15:0] sb;
      logic [63:0] p1;
      logic [63:0] p2;
      logic [63:0] p3;
      sa    = ah + al;
      sb    = bh + bl;
      p1    = 64'(ah) * 64'(bh);
      p2    = 64'(al) * 64'(bl);
      p3    = 64'(sa) * 64'(sb);
      e.res = p1 * 64'd100000000 + (p3 - p1 - p2) * 64'd10000 + p2;
      e.err = (ah >= 16'd10000) || (al >= 16'd10000) ||
              (bh >= 16'd10000) || (bl >= 16'd10000);
      return e;
   endfunction

   // Offer one operand set and wait (bounded) for acceptance; returns just
   // after the accepting edge with in_valid dropped again.
   task automatic applyStimulus(input logic [15:0] ah, input logic [15:0] al,
                                input logic [15:0] bh, input logic [15:0] bl,
                                output bit accepted);
      int n;
      @(negedge clk);
      a_hi     = ah;
      a_lo     = al;
      b_hi     = bh;
      b_lo     = bl;
      in_valid = 1'b1;
      n        = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      accepted = 1'b0;
      if (in_ready) begin
         @(posedge clk);
         #1;
         accepted = 1'b1;
         sbQueue.push_back(modelOp(ah, al, bh, bl));
      end
      in_valid = 1'b0;
   endtask

   // Count edges until out_valid is seen, bounded at 50 cycles.
   task automatic waitOutValid(output int edges, output bit seen);
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 50) begin
         @(posedge clk);
         #1;
         edges++;
         seen = out_valid;
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_hi = '0; a_lo = '0; b_hi = '0; b_lo = '0;
      #12;
      testsRun++;
      if ({in_ready, out_valid, out_err, busy} !== 4'b1000) begin
         testsFailed++;
         $display("[TB] FAIL reset_flags: got ready/valid/err/busy=%b expected 1000",
                  {in_ready, out_valid, out_err, busy});
      end
      testsRun++;
      if (result !== 64'd0 || op_count !== 16'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_regs: got result=%0d op_count=%0d expected 0/0",
                  result, op_count);
      end
      testsRun++;
      if (mul_x !== 16'd0 || mul_y !== 16'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_mul: got mul_x=%0d mul_y=%0d expected 0/0", mul_x, mul_y);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      bit   acc;
      bit   seen;
      int   edges;
      exp_t e;
      out_ready = 1'b1;
      applyStimulus(16'd1200, 16'd1300, 16'd1400, 16'd1002, acc);
      testsRun++;
      if (!acc) begin
         testsFailed++;
         $display("[TB] FAIL basic_accept: got no acceptance expected accept");
         return;
      end
      waitOutValid(edges, seen);
      testsRun++;
      if (!seen || edges != 4) begin
         testsFailed++;
         $display("[TB] FAIL basic_latency: got seen=%0d edges=%0d expected seen=1 edges=4", seen, edges);
      end
      e = sbQueue.pop_front();
      testsRun++;
      if (result !== e.res || result !== 64'd168030225302600 || out_err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL basic_result: got %0d err=%0d expected 168030225302600 err=0",
                  result, out_err);
      end
      @(posedge clk);
      #1;
      testsRun++;
      if (op_count !== 16'd1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL basic_handshake: got op_count=%0d valid=%0d ready=%0d expected 1/0/1",
                  op_count, out_valid, in_ready);
      end
   endtask

   task automatic test_max_digits();
      bit   acc;
      bit   seen;
      int   edges;
      exp_t e;
      out_ready = 1'b1;
      applyStimulus(16'd9999, 16'd9999, 16'd9999, 16'd9999, acc);
      testsRun++;
      if (!acc || mul_x !== 16'd9999 || mul_y !== 16'd9999) begin
         testsFailed++;
         $display("[TB] FAIL max_mul_hi: got acc=%0d mul_x=%0d mul_y=%0d expected 1/9999/9999",
                  acc, mul_x, mul_y);
      end
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      testsRun++;
      if (mul_x !== 16'd19998 || mul_y !== 16'd19998) begin
         testsFailed++;
         $display("[TB] FAIL max_mul_mid: got mul_x=%0d mul_y=%0d expected 19998/19998", mul_x, mul_y);
      end
      waitOutValid(edges, seen);
      e = sbQueue.pop_front();
      testsRun++;
      if (!seen || edges != 2 || result !== e.res || result !== 64'd9999999800000001) begin
         testsFailed++;
         $display("[TB] FAIL max_result: got seen=%0d edges=%0d result=%0d expected 1/2/9999999800000001",
                  seen, edges, result);
      end
      @(posedge clk);
      #1;
      testsRun++;
      if (op_count !== 16'd2) begin
         testsFailed++;
         $display("[TB] FAIL max_count: got %0d expected 2", op_count);
      end
   endtask

   task automatic test_zero_and_unit();
      bit   acc;
      bit   seen;
      int   edges;
      exp_t e;
      out_ready = 1'b1;
      applyStimulus(16'd0, 16'd0, 16'd4321, 16'd8765, acc);
      waitOutValid(edges, seen);
      e = sbQueue.pop_front();
      testsRun++;
      if (!acc || !seen || result !== e.res || result !== 64'd0 || out_err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL zero_result: got seen=%0d result=%0d err=%0d expected 1/0/0",
                  seen, result, out_err);
      end
      @(posedge clk);
      #1;
      applyStimulus(16'd1, 16'd0, 16'd0, 16'd1, acc);
      waitOutValid(edges, seen);
      e = sbQueue.pop_front();
      testsRun++;
      if (!acc || !seen || result !== e.res || result !== 64'd10000 || out_err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL unit_result: got seen=%0d result=%0d err=%0d expected 1/10000/0",
                  seen, result, out_err);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_hold();
      bit          acc;
      bit          seen;
      int          edges;
      exp_t        e;
      logic [15:0] cnt;
      out_ready = 1'b0;
      applyStimulus(16'd2345, 16'd6789, 16'd1111, 16'd4321, acc);
      waitOutValid(edges, seen);
      e = sbQueue.pop_front();
      testsRun++;
      if (!acc || !seen || result !== e.res) begin
         testsFailed++;
         $display("[TB] FAIL hold_first: got seen=%0d result=%0d expected 1/%0d", seen, result, e.res);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         a_hi     = 16'($urandom_range(0, 9999));
         b_lo     = 16'($urandom_range(0, 9999));
         @(posedge clk);
         #1;
         testsRun++;
         if (out_valid !== 1'b1 || result !== e.res || in_ready !== 1'b0 || busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL hold_cycle%0d: got valid=%0d result=%0d ready=%0d expected 1/%0d/0",
                     i, out_valid, result, in_ready, e.res);
         end
      end
      cnt = op_count;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      testsRun++;
      if (op_count !== 16'(cnt + 16'd1) || out_valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL hold_release: got op_count=%0d valid=%0d expected %0d/0",
                  op_count, out_valid, cnt + 16'd1);
      end
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      testsRun++;
      if (op_count !== 16'(cnt + 16'd1) || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL hold_once: got op_count=%0d busy=%0d expected %0d/0",
                  op_count, busy, cnt + 16'd1);
      end
   endtask

   task automatic test_error();
      bit   acc;
      bit   seen;
      int   edges;
      exp_t e;
      out_ready = 1'b1;
      applyStimulus(16'd0, 16'd10000, 16'd0, 16'd0, acc);
      waitOutValid(edges, seen);
      e = sbQueue.pop_front();
      testsRun++;
      if (!acc || !seen || out_err !== e.err || out_err !== 1'b1 || result !== 64'd0) begin
         testsFailed++;
         $display("[TB] FAIL err_flag: got seen=%0d err=%0d result=%0d expected 1/1/0",
                  seen, out_err, result);
      end
      @(posedge clk);
      #1;
      applyStimulus(16'd4321, 16'd8765, 16'd1234, 16'd5678, acc);
      waitOutValid(edges, seen);
      e = sbQueue.pop_front();
      testsRun++;
      if (!acc || !seen || out_err !== 1'b0 || result !== e.res) begin
         testsFailed++;
         $display("[TB] FAIL err_clear: got err=%0d result=%0d expected 0/%0d", out_err, result, e.res);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      bit   acc;
      bit   seen;
      bit   sawIdle;
      int   edges;
      int   acceptAt;
      exp_t e;
      out_ready = 1'b1;
      applyStimulus(16'd3141, 16'd5926, 16'd2718, 16'd2818, acc);
      e = sbQueue.pop_front();
      a_hi     = 16'd1618;
      a_lo     = 16'd339;
      b_hi     = 16'd1414;
      b_lo     = 16'd2135;
      in_valid = 1'b1;
      sawIdle  = 1'b0;
      acceptAt = 0;
      for (int n = 1; n <= 12 && acceptAt == 0; n++) begin
         @(posedge clk);
         #1;
         if (n == 4) begin
            testsRun++;
            if (!acc || out_valid !== 1'b1 || result !== e.res) begin
               testsFailed++;
               $display("[TB] FAIL b2b_first: got valid=%0d result=%0d expected 1/%0d",
                        out_valid, result, e.res);
            end
         end
         if (!busy) sawIdle = 1'b1;
         else if (sawIdle) acceptAt = n;
      end
      in_valid = 1'b0;
      testsRun++;
      if (acceptAt != 6) begin
         testsFailed++;
         $display("[TB] FAIL b2b_spacing: got next accept at edge %0d expected 6", acceptAt);
      end
      if (acceptAt != 0) begin
         sbQueue.push_back(modelOp(16'd1618, 16'd339, 16'd1414, 16'd2135));
         waitOutValid(edges, seen);
         e = sbQueue.pop_front();
         testsRun++;
         if (!seen || edges != 4 || result !== e.res) begin
            testsFailed++;
            $display("[TB] FAIL b2b_second: got seen=%0d edges=%0d result=%0d expected 1/4/%0d",
                     seen, edges, result, e.res);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset_mid_op();
      bit   acc;
      bit   seen;
      int   edges;
      bit   sawValid;
      exp_t e;
      out_ready = 1'b1;
      applyStimulus(16'd7777, 16'd2222, 16'd5555, 16'd4444, acc);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      testsRun++;
      if (!acc || mul_x !== 16'd9999 || mul_y !== 16'd9999) begin
         testsFailed++;
         $display("[TB] FAIL rst_in_mid: got mul_x=%0d mul_y=%0d expected 9999/9999", mul_x, mul_y);
      end
      #1;
      rst_n = 1'b0;
      #1;
      void'(sbQueue.pop_front());
      testsRun++;
      if ({in_ready, out_valid, out_err, busy} !== 4'b1000 || result !== 64'd0 ||
          op_count !== 16'd0 || mul_x !== 16'd0 || mul_y !== 16'd0) begin
         testsFailed++;
         $display("[TB] FAIL rst_mid_values: got flags=%b result=%0d op_count=%0d mul=%0d/%0d expected 1000/0/0/0/0",
                  {in_ready, out_valid, out_err, busy}, result, op_count, mul_x, mul_y);
      end
      sawValid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (out_valid) sawValid = 1'b1;
      end
      testsRun++;
      if (sawValid) begin
         testsFailed++;
         $display("[TB] FAIL rst_mid_no_valid: got out_valid pulse expected none");
      end
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(16'd1234, 16'd5678, 16'd8765, 16'd4321, acc);
      waitOutValid(edges, seen);
      e = sbQueue.pop_front();
      testsRun++;
      if (!acc || !seen || result !== e.res || out_err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL rst_fresh_result: got seen=%0d result=%0d err=%0d expected 1/%0d/0",
                  seen, result, out_err, e.res);
      end
      @(posedge clk);
      #1;
      testsRun++;
      if (op_count !== 16'd1) begin
         testsFailed++;
         $display("[TB] FAIL rst_fresh_count: got %0d expected 1", op_count);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max_digits();
      test_zero_and_unit();
      test_hold();
      test_error();
      test_back_to_back();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
